// File: rtl/cas_player.sv
// cas_player: cassette tape playback. Each byte is sent as an FSK frame with an
// optional 2400 Hz leader tone, then one start symbol, eight data symbols sent
// LSB first, and two stop symbols. All tape timing advances on the 3.58 MHz
// clk_en tick and only while the motor is on.
module cas_player #(
  parameter int HALF_2400 = 746,
  parameter int HALF_1200 = 1492,
  parameter int SHORT_HDR = 4000,
  parameter int LONG_HDR  = 16000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       motor,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic [1:0] in_hdr,
  output logic       in_ready,
  output logic       cas_audio,
  output logic       busy
);

  localparam logic [10:0] HALF_2400_C = 11'(HALF_2400);
  localparam logic [10:0] HALF_1200_C = 11'(HALF_1200);
  localparam logic [13:0] SHORT_HDR_C = 14'(SHORT_HDR);
  localparam logic [13:0] LONG_HDR_C  = 14'(LONG_HDR);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  byte_r;
  logic        hdr_long_r;
  logic [10:0] half_cnt_r;
  logic [13:0] hdr_cnt_r;
  logic [3:0]  sym_idx_r;
  logic [1:0]  sub_r;
  logic        audio_r;
  logic        ready_r;
  logic        busy_r;

  logic        sym_bit_s;
  logic [2:0]  data_sel_s;
  logic [10:0] half_len_s;
  logic [1:0]  last_sub_s;
  logic [13:0] hdr_target_s;
  logic        tick_s;
  logic        half_done_s;

  // Decode the current symbol: its bit value, half length and number of halves.
  always_comb begin
    sym_bit_s    = 1'b0;
    data_sel_s   = sym_idx_r[2:0] - 3'd1;
    half_len_s   = HALF_1200_C;
    last_sub_s   = 2'd1;
    hdr_target_s = hdr_long_r ? LONG_HDR_C : SHORT_HDR_C;
    case (state_r)
      HEADER:  sym_bit_s = 1'b1;
      START:   sym_bit_s = 1'b0;
      DATA:    sym_bit_s = byte_r[data_sel_s];
      STOP:    sym_bit_s = 1'b1;
      default: sym_bit_s = 1'b0;
    endcase
    half_len_s  = sym_bit_s ? HALF_2400_C : HALF_1200_C;
    // A "1" symbol is two 2400 Hz cycles (four halves); a header cycle is one.
    last_sub_s  = (sym_bit_s && (state_r != HEADER)) ? 2'd3 : 2'd1;
    tick_s      = clk_en & motor & (state_r != IDLE);
    half_done_s = tick_s & ((half_cnt_r + 11'd1) == half_len_s);
  end

  // Frame sequencer: acceptance, header/symbol timing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      byte_r     <= 8'h00;
      hdr_long_r <= 1'b0;
      half_cnt_r <= 11'd0;
      hdr_cnt_r  <= 14'd0;
      sym_idx_r  <= 4'd0;
      sub_r      <= 2'd0;
      audio_r    <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          audio_r    <= 1'b0;
          half_cnt_r <= 11'd0;
          hdr_cnt_r  <= 14'd0;
          sym_idx_r  <= 4'd0;
          sub_r      <= 2'd0;
          if (in_valid) begin
            byte_r     <= in_byte;
            hdr_long_r <= in_hdr[1];
            state_r    <= (in_hdr != 2'b00) ? HEADER : START;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
          end
        end

        HEADER: begin
          if (tick_s) begin
            // High for the first half of each cycle, low for the second.
            audio_r <= ~sub_r[0];
            if (half_done_s) begin
              half_cnt_r <= 11'd0;
              if (sub_r == 2'd1) begin
                sub_r <= 2'd0;
                if ((hdr_cnt_r + 14'd1) == hdr_target_s) begin
                  hdr_cnt_r <= 14'd0;
                  state_r   <= START;
                end else begin
                  hdr_cnt_r <= hdr_cnt_r + 14'd1;
                end
              end else begin
                sub_r <= sub_r + 2'd1;
              end
            end else begin
              half_cnt_r <= half_cnt_r + 11'd1;
            end
          end
        end

        START, DATA, STOP: begin
          if (tick_s) begin
            audio_r <= ~sub_r[0];
            if (half_done_s) begin
              half_cnt_r <= 11'd0;
              if (sub_r == last_sub_s) begin
                sub_r     <= 2'd0;
                sym_idx_r <= sym_idx_r + 4'd1;
                if (sym_idx_r == 4'd10) begin
                  // Final half of the second stop symbol: frame complete.
                  state_r   <= IDLE;
                  sym_idx_r <= 4'd0;
                  audio_r   <= 1'b0;
                  ready_r   <= 1'b1;
                  busy_r    <= 1'b0;
                end else if (sym_idx_r == 4'd0) begin
                  state_r <= DATA;
                end else if (sym_idx_r == 4'd8) begin
                  state_r <= STOP;
                end else begin
                  state_r <= state_r;
                end
              end else begin
                sub_r <= sub_r + 2'd1;
              end
            end else begin
              half_cnt_r <= half_cnt_r + 11'd1;
            end
          end
        end

        default: begin
          state_r <= IDLE;
          audio_r <= 1'b0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_r;
  assign busy      = busy_r;
  assign cas_audio = audio_r;

endmodule
